// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one external memory read port between the program cache (port 0)
//   and the data cache (port 1). Grants one line-fill miss at a time
//   (round-robin), issues a line-aligned read, gathers BEATS beats into a
//   line buffer and delivers the whole line with a one-cycle fill strobe.
//
//   State table:
//     state   | meaning
//     --------+-----------------------------------------------------------
//     IDLE    | arbitrate between requesters, ready only to the winner
//     ISSUE   | mem_req_valid held until memory accepts the read
//     FILL    | collecting beats into line_buf, beat 0 in the LSBs
//     DELIVER | fill_valid high for one cycle, then back to IDLE
//
// Ports:
//   clk, reset (async, active-low)
//   req0_* / req1_*   : miss request handshakes (program / data cache)
//   mem_req_*         : memory read request, byte address {line, 6'b0}
//   mem_rdata_*       : returned beats with last marker
//   fill_*            : assembled line delivery, held until next delivery
//   busy              : not in IDLE
//   timeout_err       : sticky, transaction abandoned for lack of progress
//   proto_err         : sticky, last-marker mismatch or stray beat
module cache_refill_arbiter #(
    parameter int LINE_WIDTH      = 512,
    parameter int BEAT_WIDTH      = 32,
    parameter int BEATS           = LINE_WIDTH / BEAT_WIDTH,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int TIMEOUT         = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] req0_addr,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] req1_addr,
    output logic                       req1_ready,
    output logic                       mem_req_valid,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_rdata_valid,
    input  logic [BEAT_WIDTH-1:0]      mem_rdata,
    input  logic                       mem_rdata_last,
    output logic                       fill_valid,
    output logic                       fill_port,
    output logic [LINE_ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0]      fill_data,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       proto_err
);

    localparam int CNT_W = $clog2(BEATS);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Down-counter: loaded with TIMEOUT-1 so the abort fires on the
    // TIMEOUT-th consecutive cycle without progress.
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FILL, DELIVER} state_t;

    state_t                     state;
    logic                       last_grant;
    logic                       port_q;
    logic [LINE_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]           cnt;
    logic [TMR_W-1:0]           timer;
    logic [LINE_WIDTH-1:0]      line_buf;
    logic [LINE_WIDTH-1:0]      line_next;
    logic                       grant0;
    logic                       grant1;

    always_comb begin
        // Contention goes to the port that was not granted last.
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        line_next = line_buf;
        line_next[cnt*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
    end

    assign req0_ready    = (state == IDLE) && grant0;
    assign req1_ready    = (state == IDLE) && grant1;
    assign mem_req_valid = (state == ISSUE);
    assign mem_req_addr  = 32'({addr_q, 6'b0});
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            port_q      <= 1'b0;
            addr_q      <= '0;
            cnt         <= '0;
            timer       <= '0;
            line_buf    <= '0;
            fill_valid  <= 1'b0;
            fill_port   <= 1'b0;
            fill_addr   <= '0;
            fill_data   <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (mem_rdata_valid && state != FILL)
                proto_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        addr_q     <= req0_addr;
                        port_q     <= 1'b0;
                        last_grant <= 1'b0;
                        timer      <= TMR_LOAD;
                        state      <= ISSUE;
                    end else if (req1_ready) begin
                        addr_q     <= req1_addr;
                        port_q     <= 1'b1;
                        last_grant <= 1'b1;
                        timer      <= TMR_LOAD;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        timer <= TMR_LOAD;
                        state <= FILL;
                    end else if (timer == '0) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                FILL: begin
                    if (mem_rdata_valid) begin
                        line_buf <= line_next;
                        timer    <= TMR_LOAD;
                        // Beat count decides completion; the last marker is
                        // only cross-checked.
                        if (cnt == LAST_BEAT) begin
                            if (!mem_rdata_last)
                                proto_err <= 1'b1;
                            fill_valid <= 1'b1;
                            fill_port  <= port_q;
                            fill_addr  <= addr_q;
                            fill_data  <= line_next;
                            state      <= DELIVER;
                        end else begin
                            if (mem_rdata_last)
                                proto_err <= 1'b1;
                            cnt <= cnt + 1'b1;
                        end
                    end else if (timer == '0) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DELIVER: begin
                    fill_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid = 1'b0;
    logic [25:0]  req0_addr = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [25:0]  req1_addr = '0;
    logic         req1_ready;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready = 1'b0;
    logic         mem_rdata_valid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rdata_last = 1'b0;
    logic         fill_valid;
    logic         fill_port;
    logic [25:0]  fill_addr;
    logic [511:0] fill_data;
    logic         busy;
    logic         timeout_err;
    logic         proto_err;

    int total = 0;
    int bad = 0;

    cache_refill_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_ready      (req1_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .mem_rdata_last  (mem_rdata_last),
        .fill_valid      (fill_valid),
        .fill_port       (fill_port),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [511:0] line_of(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Entered at an IDLE cycle with request valids already driven.
    task automatic serve(input bit p, input logic [25:0] a, input logic [31:0] base,
                         input int gap, input int bp, input int last_at, input bit drop);
        #1;
        chk("ready0", req0_ready, p == 1'b0);
        chk("ready1", req1_ready, p == 1'b1);
        step();
        if (drop) begin
            if (p) req1_valid = 1'b0;
            else   req0_valid = 1'b0;
        end
        chk("issue_valid", mem_req_valid, 1'b1);
        chk("issue_addr", mem_req_addr, {a, 6'b0});
        mem_req_ready = 1'b0;
        repeat (bp) begin
            step();
            chk("bp_valid", mem_req_valid, 1'b1);
            chk("bp_addr", mem_req_addr, {a, 6'b0});
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            repeat (gap) begin
                mem_rdata_valid = 1'b0;
                step();
            end
            mem_rdata_valid = 1'b1;
            mem_rdata       = base + 32'(i);
            mem_rdata_last  = (i == last_at);
            step();
        end
        mem_rdata_valid = 1'b0;
        mem_rdata_last  = 1'b0;
        chk("fill_valid", fill_valid, 1'b1);
        chk("fill_port", fill_port, p);
        chk("fill_addr", fill_addr, a);
        chk("fill_data", fill_data, line_of(base));
        step();
        chk("fill_drop", fill_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("fill_hold", fill_data, line_of(base));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    int  n;
    bit  seen;

    initial begin
        // reset state
        #1;
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_mem_req", mem_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_fill_data", fill_data, '0);
        chk("rst_errs", {timeout_err, proto_err}, 2'b00);
        do_reset();

        // single request, minimum latency
        req0_valid = 1'b1; req0_addr = 26'h0000123;
        serve(1'b0, 26'h0000123, 32'h0, 0, 0, 15, 1'b1);
        chk("t1_addr_byte", {26'h0000123, 6'b0}, 32'h000048C0);
        chk("t1_lo", fill_data[31:0], 32'h0);
        chk("t1_hi", fill_data[511:480], 32'hF);
        chk("t1_errs", {timeout_err, proto_err}, 2'b00);

        // simultaneous requests after reset
        do_reset();
        req0_valid = 1'b1; req0_addr = 26'h0000200;
        req1_valid = 1'b1; req1_addr = 26'h0000300;
        serve(1'b0, 26'h0000200, 32'h1000, 0, 0, 15, 1'b1);
        serve(1'b1, 26'h0000300, 32'h2000, 0, 0, 15, 1'b1);

        // fairness: req0 held, req1 arrives later
        req0_valid = 1'b1; req0_addr = 26'h0000400;
        serve(1'b0, 26'h0000400, 32'h3000, 0, 0, 15, 1'b0);
        req1_valid = 1'b1; req1_addr = 26'h0000500;
        serve(1'b1, 26'h0000500, 32'h4000, 0, 0, 15, 1'b1);
        serve(1'b0, 26'h0000400, 32'h5000, 0, 0, 15, 1'b1);
        chk("fair_errs", {timeout_err, proto_err}, 2'b00);

        // backpressure and gapped beats
        req1_valid = 1'b1; req1_addr = 26'h3FFFFFF;
        serve(1'b1, 26'h3FFFFFF, 32'hA5A50000, 3, 5, 15, 1'b1);
        chk("bp_errs", {timeout_err, proto_err}, 2'b00);

        // timeout: request accepted, no beats ever
        req0_valid = 1'b1; req0_addr = 26'h0000777;
        step();
        req0_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        n = 0; seen = 1'b0;
        while (busy && n < 1100) begin
            step();
            n++;
            if (fill_valid) seen = 1'b1;
        end
        chk("to_cycles", 32'(n), 32'd1023);
        chk("to_err", timeout_err, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_nofill", seen, 1'b0);
        chk("to_proto", proto_err, 1'b0);
        req0_valid = 1'b1; req0_addr = 26'h0000778;
        serve(1'b0, 26'h0000778, 32'h6000, 0, 0, 15, 1'b1);
        chk("to_sticky", timeout_err, 1'b1);

        // early last marker
        req1_valid = 1'b1; req1_addr = 26'h0000900;
        serve(1'b1, 26'h0000900, 32'h7000, 0, 0, 5, 1'b1);
        chk("pe_err", proto_err, 1'b1);

        // reset mid-fill, then stray beats in IDLE
        req0_valid = 1'b1; req0_addr = 26'h0000ABC;
        step();
        req0_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 32'(i);
            step();
        end
        mem_rdata_valid = 1'b0;
        chk("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_mem_req", {mem_req_valid, mem_req_addr}, '0);
        chk("mr_fill", {fill_valid, fill_port, fill_addr}, '0);
        chk("mr_fill_data", fill_data, '0);
        chk("mr_errs", {timeout_err, proto_err}, 2'b00);
        step();
        reset = 1'b1;
        step();
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD0000 + 32'(i);
            step();
            if (fill_valid) seen = 1'b1;
        end
        mem_rdata_valid = 1'b0;
        repeat (20) begin
            step();
            if (fill_valid) seen = 1'b1;
        end
        chk("stray_nofill", seen, 1'b0);
        chk("stray_proto", proto_err, 1'b1);
        chk("stray_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
